// File: rtl/k2_pkg.sv
// Shared types and constants for the K2 instruction sequencer.
// Holds the FSM state encoding, destination codes and instruction field positions.
package k2_pkg;

  localparam int K2_PC_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_DECODE  = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_HALT    = 2'b11
  } k2_state_t;

  localparam logic [1:0] DEST_RA   = 2'b00;
  localparam logic [1:0] DEST_RB   = 2'b01;
  localparam logic [1:0] DEST_RO   = 2'b10;
  localparam logic [1:0] DEST_NONE = 2'b11;

  localparam int BIT_J       = 7;
  localparam int BIT_C       = 6;
  localparam int BIT_DEST_HI = 6;
  localparam int BIT_DEST_LO = 5;
  localparam int BIT_SREG    = 4;
  localparam int BIT_S       = 3;
  localparam int IMM_HI      = 2;
  localparam int TGT_HI      = 3;

  // Write enables are ordered {RO,RB,RA}.
  function automatic logic [2:0] dest_onehot(input logic [1:0] dest);
    logic [2:0] en;
    en = 3'b000;
    case (dest)
      DEST_RA:   en = 3'b001;
      DEST_RB:   en = 3'b010;
      DEST_RO:   en = 3'b100;
      DEST_NONE: en = 3'b000;
      default:   en = 3'b000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/k2_decode.sv
// Combinational field extraction from the latched instruction word.
// Produces jump/condition flags, jump target, destination and datapath controls.
module k2_decode
  import k2_pkg::*;
(
  input  logic [7:0] ir,
  output logic       is_jump,
  output logic       is_cond,
  output logic [3:0] target,
  output logic [1:0] dest,
  output logic       mux_sel,
  output logic       sub,
  output logic [2:0] imm
);

  assign is_jump = ir[BIT_J];
  assign is_cond = ir[BIT_C];
  assign target  = ir[TGT_HI:0];
  assign dest    = ir[BIT_DEST_HI:BIT_DEST_LO];
  assign mux_sel = ir[BIT_SREG];
  assign sub     = ir[BIT_S];
  assign imm     = ir[IMM_HI:0];

endmodule

// File: rtl/k2_sequencer.sv
// K2 three-cycle FETCH/DECODE/EXECUTE sequencer with PC, carry flag and HALT.
// Define K2_SINGLE_STEP_EN to add step_i, which gates leaving FETCH.
module k2_sequencer
  import k2_pkg::*;
#(
  parameter int PC_W = K2_PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
`ifdef K2_SINGLE_STEP_EN
  input  logic            step_i,
`endif
  input  logic [7:0]      instr_i,
  input  logic            carry_i,
  output logic [PC_W-1:0] pc_o,
  output logic [2:0]      en_reg_o,
  output logic            en_mux1_o,
  output logic            alu_sub_o,
  output logic [2:0]      imm_o,
  output logic            carry_flag_o,
  output logic [1:0]      state_o,
  output logic            halt_o
);

  k2_state_t       state;
  k2_state_t       next_state;
  logic [7:0]      ir;
  logic [PC_W-1:0] pc;
  logic            flag;
  logic            fetch_go;

  logic            is_jump;
  logic            is_cond;
  logic [3:0]      target;
  logic [1:0]      dest;
  logic            mux_sel;
  logic            sub;
  logic [2:0]      imm;

  logic [PC_W-1:0] target_pc;
  logic [PC_W-1:0] pc_inc;
  logic            self_jump;

`ifdef K2_SINGLE_STEP_EN
  assign fetch_go = step_i;
`else
  assign fetch_go = 1'b1;
`endif

  k2_decode u_decode (
    .ir      (ir),
    .is_jump (is_jump),
    .is_cond (is_cond),
    .target  (target),
    .dest    (dest),
    .mux_sel (mux_sel),
    .sub     (sub),
    .imm     (imm)
  );

  assign target_pc = PC_W'(target);
  assign pc_inc    = pc + PC_W'(1);
  // Only an unconditional jump onto itself halts; a taken conditional one just loops.
  assign self_jump = is_jump & ~is_cond & (target_pc == pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:   next_state = fetch_go ? ST_DECODE : ST_FETCH;
      ST_DECODE:  next_state = ST_EXECUTE;
      ST_EXECUTE: next_state = self_jump ? ST_HALT : ST_FETCH;
      ST_HALT:    next_state = ST_HALT;
      default:    next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    en_reg_o  = 3'b000;
    en_mux1_o = 1'b0;
    alu_sub_o = 1'b0;
    imm_o     = 3'b000;
    halt_o    = 1'b0;
    case (state)
      ST_DECODE: begin
        en_mux1_o = mux_sel;
        alu_sub_o = sub;
        imm_o     = imm;
      end
      ST_EXECUTE: begin
        en_mux1_o = mux_sel;
        alu_sub_o = sub;
        imm_o     = imm;
        en_reg_o  = is_jump ? 3'b000 : dest_onehot(dest);
      end
      ST_HALT:  halt_o = 1'b1;
      default: ;
    endcase
  end

  // The instruction register tracks the ROM throughout FETCH so a stalled fetch sees fresh data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir   <= 8'h00;
      pc   <= '0;
      flag <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: ir <= instr_i;
        ST_EXECUTE: begin
          if (!is_jump) begin
            flag <= carry_i;
            pc   <= pc_inc;
          end else if (!is_cond) begin
            pc <= target_pc;
          end else if (flag) begin
            pc   <= target_pc;
            flag <= 1'b0;
          end else begin
            pc <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_o         = pc;
  assign carry_flag_o = flag;
  assign state_o      = state;

endmodule

// File: tb/tb_k2_sequencer.sv
// Self-checking bench for k2_sequencer: directed program scenarios plus random programs
// compared against an instruction-level architectural model.
module tb_k2_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] instr_i;
  logic       carry_i;
  logic [3:0] pc_o;
  logic [2:0] en_reg_o;
  logic       en_mux1_o;
  logic       alu_sub_o;
  logic [2:0] imm_o;
  logic       carry_flag_o;
  logic [1:0] state_o;
  logic       halt_o;
`ifdef K2_SINGLE_STEP_EN
  logic       step_i;
`endif

  logic [7:0] rom [16];
  int checks;
  int errors;
  int mpc;
  int mflag;
  bit mhalt;
  bit halted;

  assign instr_i = rom[pc_o];

  k2_sequencer #(.PC_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef K2_SINGLE_STEP_EN
    .step_i       (step_i),
`endif
    .instr_i      (instr_i),
    .carry_i      (carry_i),
    .pc_o         (pc_o),
    .en_reg_o     (en_reg_o),
    .en_mux1_o    (en_mux1_o),
    .alu_sub_o    (alu_sub_o),
    .imm_o        (imm_o),
    .carry_flag_o (carry_flag_o),
    .state_o      (state_o),
    .halt_o       (halt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  // Pulse reset asynchronously between edges, check reset values, release on a falling edge.
  task automatic applyReset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_pc", pc_o, 0);
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_halt", halt_o, 0);
    checkOutput("rst_flag", carry_flag_o, 0);
    checkOutput("rst_outs", {en_reg_o, en_mux1_o, alu_sub_o, imm_o}, 0);
    @(negedge clk);
    reset = 1'b1;
    mpc = 0;
    mflag = 0;
    mhalt = 0;
  endtask

  // Runs one instruction from FETCH; cin is the carry presented during EXECUTE.
  task automatic applyStimulus(input logic cin, output bit hlt);
    logic [7:0] ins;
    int j, c, tgt, d, mux, sb, imm, en;
    ins = rom[mpc];
    j   = ins / 128;
    c   = (ins / 64) % 2;
    d   = (ins / 32) % 4;
    mux = (ins / 16) % 2;
    sb  = (ins / 8) % 2;
    imm = ins % 8;
    tgt = ins % 16;
    en  = (j == 1 || d == 3) ? 0 : (1 << d);
    carry_i = 1'($urandom);
    checkOutput("fetch_state", state_o, 0);
    checkOutput("fetch_outs", {en_reg_o, en_mux1_o, alu_sub_o, imm_o}, 0);
    checkOutput("fetch_pc", pc_o, mpc);
    @(negedge clk);
    checkOutput("dec_state", state_o, 1);
    checkOutput("dec_en", en_reg_o, 0);
    checkOutput("dec_ctrl", {en_mux1_o, alu_sub_o, imm_o}, mux * 16 + sb * 8 + imm);
    @(negedge clk);
    checkOutput("exe_state", state_o, 2);
    checkOutput("exe_en", en_reg_o, en);
    checkOutput("exe_ctrl", {en_mux1_o, alu_sub_o, imm_o}, mux * 16 + sb * 8 + imm);
    carry_i = cin;
    if (j == 0) begin
      mflag = cin;
      mpc = (mpc + 1) % 16;
    end else if (c == 0) begin
      if (tgt == mpc) mhalt = 1;
      else mpc = tgt;
    end else if (mflag == 1) begin
      mpc = tgt;
      mflag = 0;
    end else begin
      mpc = (mpc + 1) % 16;
    end
    @(negedge clk);
    carry_i = 1'($urandom);
    checkOutput("post_pc", pc_o, mpc);
    checkOutput("post_flag", carry_flag_o, mflag);
    checkOutput("post_state", state_o, mhalt ? 3 : 0);
    checkOutput("post_halt", halt_o, mhalt);
    hlt = mhalt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    carry_i = 1'b0;
`ifdef K2_SINGLE_STEP_EN
    step_i = 1'b1;
`endif
    clearRom();
    #1 reset = 1'b0;

    // RA <= 5, RB <= ALU with carry, then taken JC 7.
    rom[0] = 8'h05; rom[1] = 8'h38; rom[2] = 8'hC7;
    applyReset();
    applyStimulus(1'b0, halted);
    applyStimulus(1'b1, halted);
    checkOutput("req032_flag", carry_flag_o, 1);
    applyStimulus(1'b0, halted);
    checkOutput("req033_taken_pc", pc_o, 7);
    checkOutput("req033_taken_flag", carry_flag_o, 0);

    // Same program with the flag left clear: JC falls through.
    applyReset();
    applyStimulus(1'b0, halted);
    applyStimulus(1'b0, halted);
    applyStimulus(1'b1, halted);
    checkOutput("req033_fall_pc", pc_o, 3);

    // Jump to 15, then a plain instruction there wraps the PC.
    clearRom();
    rom[0] = 8'h8F; rom[15] = 8'h00;
    applyReset();
    applyStimulus(1'b1, halted);
    applyStimulus(1'b1, halted);
    checkOutput("req034_wrap", pc_o, 0);

    // Taken conditional jump onto itself does not halt.
    clearRom();
    rom[0] = 8'h08; rom[1] = 8'hC1;
    applyReset();
    applyStimulus(1'b1, halted);
    applyStimulus(1'b0, halted);
    checkOutput("selfjc_nohalt", halt_o, 0);

    // Unconditional self-jump halts and stays put until reset.
    clearRom();
    rom[0] = 8'h84; rom[4] = 8'h84;
    applyReset();
    applyStimulus(1'b0, halted);
    applyStimulus(1'b0, halted);
    for (int i = 0; i < 20; i++) begin
      carry_i = 1'($urandom);
      @(negedge clk);
      checkOutput("halt_hold_pc", pc_o, 4);
      checkOutput("halt_hold_state", state_o, 3);
      checkOutput("halt_hold_outs", {en_reg_o, en_mux1_o, alu_sub_o, imm_o}, 0);
    end
    #2 reset = 1'b0;
    #1;
    checkOutput("halt_rst_pc", pc_o, 0);
    checkOutput("halt_rst_halt", halt_o, 0);
    @(negedge clk);
    reset = 1'b1;

    // Reset during an RA write drops the enable immediately.
    clearRom();
    rom[0] = 8'h05;
    applyReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_pre_en", en_reg_o, 3'b001);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_en", en_reg_o, 0);
    checkOutput("abort_state", state_o, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_first_fetch", state_o, 1);
    checkOutput("abort_pc", pc_o, 0);

`ifdef K2_SINGLE_STEP_EN
    applyReset();
    step_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("step_hold_state", state_o, 0);
      checkOutput("step_hold_pc", pc_o, 0);
    end
    step_i = 1'b1;
    applyStimulus(1'b0, halted);
`endif

    // Random programs against the instruction-level model.
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      applyReset();
      for (int k = 0; k < 15; k++) begin
        applyStimulus(1'($urandom), halted);
        if (halted) break;
      end
      if (halted) begin
        repeat (3) @(negedge clk);
        checkOutput("rand_halt_pc", pc_o, mpc);
        checkOutput("rand_halt_state", state_o, 3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
